// File: rtl/fp_norm_pkg.sv
// fp_norm_pkg: shared defaults, flag bundle and shift-count width helper for the normaliser
package fp_norm_pkg;
  localparam int DEF_WIDTH = 25;
  localparam int DEF_EXP_W = 8;
  typedef struct packed {
    logic rshift;
    logic sticky;
    logic zero;
    logic denorm;
    logic ovf;
  } flags_t;
  function automatic int cnt_w(input int w);
    return $clog2(w);
  endfunction
endpackage

// File: rtl/lzc_tree.sv
// lzc_tree: recursive combinational leading-zero counter with all-zero flag
module lzc_tree #(
  parameter int N = 24,
  parameter int CW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  d,
  output logic [CW-1:0] cnt,
  output logic          zero
);
  if (N == 1) begin : g_leaf
    assign cnt = '0;
    assign zero = ~d[0];
  end else begin : g_node
    localparam int H = 1 << (CW - 1);
    localparam int L = N - H;
    localparam int HW = (H > 1) ? $clog2(H) : 1;
    localparam int LW = (L > 1) ? $clog2(L) : 1;
    logic [HW-1:0] hc;
    logic [LW-1:0] lc;
    logic hz, lz;
    lzc_tree #(.N(H)) u_hi (.d(d[N-1 -: H]), .cnt(hc), .zero(hz));
    lzc_tree #(.N(L)) u_lo (.d(d[L-1:0]), .cnt(lc), .zero(lz));
    assign zero = hz & lz;
    assign cnt = hz ? CW'(H) + CW'(lc) : CW'(hc);
  end
endmodule

// File: rtl/lzc_norm_pipe.sv
// lzc_norm_pipe: two-stage valid/ready significand normaliser with carry, subnormal and zero handling
module lzc_norm_pipe
  import fp_norm_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int EXP_W = DEF_EXP_W,
  parameter int CNT_W = cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_mant,
  input  logic [EXP_W-1:0] in_exp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_mant,
  output logic [EXP_W-1:0] out_exp,
  output logic [CNT_W-1:0] out_shift,
  output logic             out_rshift,
  output logic             out_sticky,
  output logic             out_zero,
  output logic             out_denorm,
  output logic             out_ovf
);
  localparam int LW = $clog2(WIDTH - 1);
  localparam int MW = (EXP_W > CNT_W ? EXP_W : CNT_W) + 1;
  logic             s1_valid, s1_carry, s1_zero, s2_adv, normal, lz_zero;
  logic [LW-1:0]    lz_cnt;
  logic [CNT_W-1:0] s1_lz, shift_n;
  logic [WIDTH-1:0] s1_mant, mant_n;
  logic [EXP_W-1:0] s1_exp, exp_n;
  logic [MW-1:0]    lz_m, exp_m, lsh_m;
  flags_t           flags_n, flags_q;
  lzc_tree #(.N(WIDTH - 1)) u_lzc (.d(in_mant[WIDTH-2:0]), .cnt(lz_cnt), .zero(lz_zero));
  assign s2_adv = ~out_valid | out_ready;
  assign in_ready = ~s1_valid | s2_adv;
  assign {out_rshift, out_sticky, out_zero, out_denorm, out_ovf} = flags_q;
  always_comb begin
    lz_m = MW'(s1_lz);
    exp_m = MW'(s1_exp);
    normal = lz_m < exp_m;
    lsh_m = normal ? lz_m : (exp_m == '0 ? '0 : exp_m - 1'b1);
    shift_n = (s1_carry | s1_zero) ? '0 : CNT_W'(lsh_m);
    mant_n = s1_zero ? '0 : s1_carry ? s1_mant >> 1 : s1_mant << shift_n;
    exp_n = s1_zero ? '0 : s1_carry ? s1_exp + 1'b1 : normal ? s1_exp - EXP_W'(s1_lz) : '0;
    flags_n.rshift = s1_carry;
    flags_n.sticky = s1_carry & s1_mant[0];
    flags_n.zero = s1_zero;
    flags_n.denorm = ~s1_carry & ~s1_zero & ~normal;
    flags_n.ovf = s1_carry & (&exp_n);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_carry <= 1'b0;
      s1_zero <= 1'b0;
      s1_lz <= '0;
      s1_mant <= '0;
      s1_exp <= '0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (in_valid & in_ready) begin
        s1_carry <= in_mant[WIDTH-1];
        s1_zero <= lz_zero & ~in_mant[WIDTH-1];
        s1_lz <= CNT_W'(lz_cnt);
        s1_mant <= in_mant;
        s1_exp <= in_exp;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_mant <= '0;
      out_exp <= '0;
      out_shift <= '0;
      flags_q <= '0;
    end else begin
      if (s2_adv) out_valid <= s1_valid;
      if (s1_valid & s2_adv) begin
        out_mant <= mant_n;
        out_exp <= exp_n;
        out_shift <= shift_n;
        flags_q <= flags_n;
      end
    end
  end
endmodule

// File: tb/tb_lzc_norm_pipe.sv
// tb_lzc_norm_pipe: table-driven and sequence checks of the normaliser pipeline
module tb_lzc_norm_pipe;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [24:0] in_mant = '0;
  logic [7:0]  in_exp = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [24:0] out_mant;
  logic [7:0]  out_exp;
  logic [4:0]  out_shift;
  logic        out_rshift, out_sticky, out_zero, out_denorm, out_ovf;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [24:0] m;
    logic [7:0]  e;
    logic [24:0] xm;
    logic [7:0]  xe;
    logic [4:0]  xs;
    logic [4:0]  xf;
  } vec_t;
  vec_t vecs[14];
  lzc_norm_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_mant(in_mant), .in_exp(in_exp), .out_valid(out_valid), .out_ready(out_ready),
    .out_mant(out_mant), .out_exp(out_exp), .out_shift(out_shift),
    .out_rshift(out_rshift), .out_sticky(out_sticky), .out_zero(out_zero),
    .out_denorm(out_denorm), .out_ovf(out_ovf)
  );
  always #5 clk = ~clk;
  function automatic logic [4:0] flags();
    return {out_rshift, out_sticky, out_zero, out_denorm, out_ovf};
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask
  task automatic beat(input logic [24:0] m, input logic [7:0] e);
    @(negedge clk);
    in_valid = 1'b1;
    in_mant = m;
    in_exp = e;
    chk("in_ready_before_beat", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask
  initial begin
    vecs[0]  = '{25'h0800000, 8'd100, 25'h0800000, 8'd100, 5'd0,  5'b00000};
    vecs[1]  = '{25'h1000001, 8'd254, 25'h0800000, 8'd255, 5'd0,  5'b11001};
    vecs[2]  = '{25'h0000001, 8'd100, 25'h0800000, 8'd77,  5'd23, 5'b00000};
    vecs[3]  = '{25'h0000001, 8'd10,  25'h0000200, 8'd0,   5'd9,  5'b00010};
    vecs[4]  = '{25'h0000000, 8'd50,  25'h0000000, 8'd0,   5'd0,  5'b00100};
    vecs[5]  = '{25'h1000000, 8'd10,  25'h0800000, 8'd11,  5'd0,  5'b10000};
    vecs[6]  = '{25'h0400000, 8'd100, 25'h0800000, 8'd99,  5'd1,  5'b00000};
    vecs[7]  = '{25'h0000100, 8'd1,   25'h0000100, 8'd0,   5'd0,  5'b00010};
    vecs[8]  = '{25'h0000100, 8'd0,   25'h0000100, 8'd0,   5'd0,  5'b00010};
    vecs[9]  = '{25'h0100000, 8'd3,   25'h0400000, 8'd0,   5'd2,  5'b00010};
    vecs[10] = '{25'h0100000, 8'd4,   25'h0800000, 8'd1,   5'd3,  5'b00000};
    vecs[11] = '{25'h0FFFFFF, 8'd5,   25'h0FFFFFF, 8'd5,   5'd0,  5'b00000};
    vecs[12] = '{25'h1FFFFFE, 8'd1,   25'h0FFFFFF, 8'd2,   5'd0,  5'b10000};
    vecs[13] = '{25'h0000000, 8'd0,   25'h0000000, 8'd0,   5'd0,  5'b00100};
    #12;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_mant", 64'(out_mant), 64'd0);
    chk("reset_out_exp_shift", 64'({out_exp, out_shift}), 64'd0);
    chk("reset_flags", 64'(flags()), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("in_ready_after_reset", 64'(in_ready), 64'd1);
    chk("out_valid_after_reset", 64'(out_valid), 64'd0);
    for (int i = 0; i < 14; i++) begin
      beat(vecs[i].m, vecs[i].e);
      chk($sformatf("v%0d_latency_early", i), 64'(out_valid), 64'd0);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_out_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("v%0d_mant", i), 64'(out_mant), 64'(vecs[i].xm));
      chk($sformatf("v%0d_exp", i), 64'(out_exp), 64'(vecs[i].xe));
      chk($sformatf("v%0d_shift", i), 64'(out_shift), 64'(vecs[i].xs));
      chk($sformatf("v%0d_flags", i), 64'(flags()), 64'(vecs[i].xf));
    end
    @(posedge clk);
    #1 chk("drained", 64'(out_valid), 64'd0);
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_mant = 25'h0800000;
    in_exp = 8'd10;
    @(posedge clk);
    #1 in_exp = 8'd20;
    @(posedge clk);
    #1 in_exp = 8'd30;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_in_ready", c), 64'(in_ready), 64'd0);
      chk($sformatf("stall%0d_out_valid", c), 64'(out_valid), 64'd1);
      chk($sformatf("stall%0d_hold", c), 64'({out_mant, out_exp, out_shift, flags()}),
          64'({25'h0800000, 8'd10, 5'd0, 5'd0}));
    end
    out_ready = 1'b1;
    #1 chk("release_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("order_b", 64'({out_valid, out_exp}), 64'({1'b1, 8'd20}));
    @(negedge clk);
    chk("order_c", 64'({out_valid, out_exp}), 64'({1'b1, 8'd30}));
    @(negedge clk);
    chk("order_empty", 64'(out_valid), 64'd0);
    beat(25'h0800000, 8'd40);
    @(negedge clk);
    in_valid = 1'b1;
    in_exp = 8'd41;
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("inflight_valid", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_valid", 64'(out_valid), 64'd0);
    chk("async_reset_exp", 64'(out_exp), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1 chk($sformatf("post_reset_idle%0d", c), 64'(out_valid), 64'd0);
    end
    beat(25'h0000001, 8'd100);
    chk("post_reset_latency_early", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1 chk("post_reset_beat", 64'({out_valid, out_mant, out_exp, out_shift}),
           64'({1'b1, 25'h0800000, 8'd77, 5'd23}));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
